user_clock_monitor: RTL

- Receive-side companion to the user clock generators. Measures a fabric-generated slow clock (the 2 MHz or 4 MHz user clock) in the 100 MHz system domain.
- Checks the clock's high and low phase widths against expected values, declares lock, and flags clock loss.
- Sits beside the clock generator. Feeds status and error counts to slow control.

---
 rtl/user_clock_monitor.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/user_clock_monitor.sv
// user_clock_monitor: measures the high/low phase widths of a slow fabric
// clock (MON_CLK_IN) in the CLK_IN domain, declares lock after LOCK_COUNT
// good periods, flags loss of clock and counts errors.
// Optional build macro USER_CLK_MON_DUTY_CHECK_EN: when defined, each phase
// is checked against its own expected width; otherwise only the total
// period is checked, tolerating duty-cycle distortion.
module user_clock_monitor #(
  parameter int EXP_HIGH   = 25,
  parameter int EXP_LOW    = 25,
  parameter int TOL        = 1,
  parameter int TIMEOUT    = 200,
  parameter int LOCK_COUNT = 8
) (
  input  logic        CLK_IN,
  input  logic        RST_N_IN,
  input  logic        MON_CLK_IN,
  input  logic        CLR_IN,
  output logic        LOCKED_OUT,
  output logic        LOSS_OUT,
  output logic [7:0]  HIGH_CNT_OUT,
  output logic [7:0]  LOW_CNT_OUT,
  output logic [15:0] ERR_CNT_OUT,
  output logic        PERIOD_OUT
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, MEAS_HIGH, MEAS_LOW} state_e;

  logic          sync1_q, sync2_q, dly_q;
  logic [2:0]    vld_pipe_q;
  logic          rise, fall, edge_any, tmo;
  logic [7:0]    phase_q, phase_d;
  logic [TW-1:0] to_q, to_d;
  state_e        state_q, state_d;
  logic [7:0]    hi_q, hi_d, lo_q, lo_d;
  logic [GW-1:0] good_q, good_d;
  logic          lock_q, lock_d, loss_q, loss_d, per_q, per_d;
  logic [15:0]   err_q, err_d, err_base;
  logic          err_inc, per_ok;

  // |v - e| <= t on unsigned 9-bit values, no wrap-around
  function automatic logic in_tol(input logic [8:0] v, input logic [8:0] e,
                                  input logic [8:0] t);
    return (v >= e) ? ((v - e) <= t) : ((e - v) <= t);
  endfunction

  // Two-flop synchronizer plus delay flop; vld_pipe masks edges until the
  // whole chain holds real samples, so a clock that is high at reset release
  // does not produce a phantom rise.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      dly_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      sync1_q    <= MON_CLK_IN;
      sync2_q    <= sync1_q;
      dly_q      <= sync2_q;
      vld_pipe_q <= {vld_pipe_q[1:0], 1'b1};
    end
  end

  assign rise     = vld_pipe_q[2] & sync2_q & ~dly_q;
  assign fall     = vld_pipe_q[2] & ~sync2_q & dly_q;
  assign edge_any = rise | fall;

  // Phase counter restarts at 1 after an edge and saturates at 255; timeout
  // counter clears on an edge and parks at TIMEOUT so the event fires once.
  always_comb begin
    phase_d = phase_q;
    to_d    = to_q;
    if (edge_any) begin
      phase_d = 8'd1;
      to_d    = '0;
    end else begin
      if (phase_q != 8'hFF) phase_d = phase_q + 8'd1;
      if (to_q != TW'(TIMEOUT)) to_d = to_q + TW'(1);
    end
  end

  assign tmo = !edge_any && (to_q == TW'(TIMEOUT - 1));

  // Counter registers
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      phase_q <= '0;
      to_q    <= '0;
    end else begin
      phase_q <= phase_d;
      to_q    <= to_d;
    end
  end

`ifdef USER_CLK_MON_DUTY_CHECK_EN
  logic hok_q, hok_d;
  // Remember whether the high phase passed, for the end-of-period verdict
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) hok_q <= 1'b0;
    else           hok_q <= hok_d;
  end
  always_comb begin
    hok_d = hok_q;
    if (state_q == MEAS_HIGH && fall)
      hok_d = (phase_q != 8'hFF) &&
              in_tol({1'b0, phase_q}, 9'(EXP_HIGH), 9'(TOL));
  end
  assign per_ok = hok_q && (phase_q != 8'hFF) &&
                  in_tol({1'b0, phase_q}, 9'(EXP_LOW), 9'(TOL));
`else
  assign per_ok = (hi_q != 8'hFF) && (phase_q != 8'hFF) &&
                  in_tol({1'b0, hi_q} + {1'b0, phase_q},
                         9'(EXP_HIGH + EXP_LOW), 9'(2 * TOL));
`endif

  // Measurement FSM, lock tracking, loss and error accounting
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    good_d   = good_q;
    lock_d   = lock_q;
    per_d    = 1'b0;
    err_inc  = 1'b0;
    loss_d   = CLR_IN ? 1'b0 : loss_q;
    err_base = CLR_IN ? 16'd0 : err_q;
    case (state_q)
      SEARCH:    if (rise) state_d = MEAS_HIGH;
      MEAS_HIGH: if (fall) begin
        hi_d    = phase_q;
        state_d = MEAS_LOW;
      end
      MEAS_LOW:  if (rise) begin
        lo_d    = phase_q;
        per_d   = 1'b1;
        state_d = MEAS_HIGH;
        if (per_ok) begin
          if (good_q != GW'(LOCK_COUNT)) good_d = good_q + GW'(1);
          if (good_d == GW'(LOCK_COUNT)) lock_d = 1'b1;
        end else begin
          good_d  = '0;
          lock_d  = 1'b0;
          err_inc = 1'b1;
        end
      end
      default:   state_d = SEARCH;
    endcase
    if (tmo) begin
      loss_d = 1'b1;
      if (state_q != SEARCH) begin
        lock_d  = 1'b0;
        good_d  = '0;
        err_inc = 1'b1;
        state_d = SEARCH;
      end
    end
    err_d = (err_inc && err_base != 16'hFFFF) ? err_base + 16'd1 : err_base;
  end

  // FSM and status registers
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state_q <= SEARCH;
      hi_q    <= '0;
      lo_q    <= '0;
      good_q  <= '0;
      lock_q  <= 1'b0;
      loss_q  <= 1'b0;
      per_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      good_q  <= good_d;
      lock_q  <= lock_d;
      loss_q  <= loss_d;
      per_q   <= per_d;
      err_q   <= err_d;
    end
  end

  assign LOCKED_OUT   = lock_q;
  assign LOSS_OUT     = loss_q;
  assign HIGH_CNT_OUT = hi_q;
  assign LOW_CNT_OUT  = lo_q;
  assign ERR_CNT_OUT  = err_q;
  assign PERIOD_OUT   = per_q;
endmodule
